// File: rtl/onchip_mem_width_adapter_pkg.sv
// ---------------------------------------------------------------------------
// onchip_mem_width_adapter_pkg
//   Shared definitions for the 32-bit to 16-bit on-chip RAM width adapter:
//   FSM state encoding, half-word selectors and the default RAM depth.
// ---------------------------------------------------------------------------
package onchip_mem_width_adapter_pkg;

    // Access sequencer states (3-bit encoding).
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // LSB of the 16-bit master address selecting the half of the 32-bit word.
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    // Number of 16-bit words implemented in the downstream RAM.
    localparam int MEM_DEPTH_DEFAULT = 15360;

endpackage : onchip_mem_width_adapter_pkg

// File: rtl/onchip_mem_width_adapter.sv
// ---------------------------------------------------------------------------
// onchip_mem_width_adapter
//   Avalon-MM adapter between a 32-bit slave port (Nios II data master side)
//   and a 16-bit single-port on-chip RAM with a one-clock read latency.
//   Each 32-bit access becomes zero, one or two 16-bit accesses, low half
//   first. Read halves are reassembled and returned in the DONE cycle, which
//   is also the only cycle with s_waitrequest low.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   s_address           32-bit word address (S_ADDR_W bits)
//   s_byteenable        32-bit byte lanes
//   s_read, s_write     request strobes (write wins if both are high)
//   s_writedata         32-bit write data
//   s_readdata          32-bit read data, valid while s_waitrequest=0
//   s_waitrequest       high while an access is in progress
//   m_address           16-bit word address {latched addr, half}
//   m_byteenable        byte lanes of the current half
//   m_chipselect        RAM select
//   m_write             RAM write strobe
//   m_writedata         RAM write data
//   m_clken             RAM clock enable, tied high
//   m_readdata          RAM output, valid one clock after the address
// ---------------------------------------------------------------------------
module onchip_mem_width_adapter
    import onchip_mem_width_adapter_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int S_ADDR_W  = 13,
    parameter int M_ADDR_W  = 14
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [S_ADDR_W-1:0] s_address,
    input  logic [3:0]          s_byteenable,
    input  logic                s_read,
    input  logic                s_write,
    input  logic [31:0]         s_writedata,
    output logic [31:0]         s_readdata,
    output logic                s_waitrequest,
    output logic [M_ADDR_W-1:0] m_address,
    output logic [1:0]          m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [15:0]         m_writedata,
    output logic                m_clken,
    input  logic [15:0]         m_readdata
);

    state_t              state_q, state_d;
    logic [S_ADDR_W-1:0] addr_q,  addr_d;
    logic [3:0]          be_q,    be_d;
    logic [31:0]         wd_q,    wd_d;
    logic                wr_q,    wr_d;
    logic [31:0]         rd_q,    rd_d;

    logic                out_of_range;
    logic                lo_used;
    logic                hi_used;

    // A 32-bit word is outside the RAM when its low half-word is.
    assign out_of_range = 32'({s_address, HALF_LO}) >= 32'(MEM_DEPTH);

    assign lo_used = (be_q[1:0] != 2'b00);
    assign hi_used = (be_q[3:2] != 2'b00);

    // -----------------------------------------------------------------------
    // State and request registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            wr_q    <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        wr_d    = wr_q;
        rd_d    = rd_q;

        case (state_q)
            ST_IDLE: begin
                if (s_read || s_write) begin
                    addr_d = s_address;
                    be_d   = s_byteenable;
                    wd_d   = s_writedata;
                    wr_d   = s_write;
                    if ((s_byteenable == 4'b0000) || out_of_range) begin
                        state_d = ST_DONE;
                    end else if (s_byteenable[1:0] != 2'b00) begin
                        state_d = ST_LO;
                    end else begin
                        state_d = ST_HI;
                    end
                end
            end

            ST_LO: begin
                state_d = hi_used ? ST_HI : ST_WAIT;
            end

            ST_HI: begin
                // The low half addressed in LO is on the RAM output now.
                if (!wr_q && lo_used) begin
                    rd_d[15:0] = m_readdata;
                end
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // The last issued half is the high one whenever it was used.
                if (!wr_q) begin
                    if (hi_used) begin
                        rd_d[31:16] = m_readdata;
                    end else begin
                        rd_d[15:0] = m_readdata;
                    end
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                // Clearing here makes skipped halves read as zero next time.
                rd_d    = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from registered state and latched request only
    // -----------------------------------------------------------------------
    always_comb begin
        s_waitrequest = 1'b1;
        s_readdata    = '0;
        m_address     = '0;
        m_byteenable  = '0;
        m_chipselect  = 1'b0;
        m_write       = 1'b0;
        m_writedata   = '0;

        case (state_q)
            ST_LO: begin
                m_chipselect = 1'b1;
                m_address    = {addr_q, HALF_LO};
                m_byteenable = be_q[1:0];
                m_write      = wr_q;
                m_writedata  = wd_q[15:0];
            end
            ST_HI: begin
                m_chipselect = 1'b1;
                m_address    = {addr_q, HALF_HI};
                m_byteenable = be_q[3:2];
                m_write      = wr_q;
                m_writedata  = wd_q[31:16];
            end
            ST_DONE: begin
                s_waitrequest = 1'b0;
                s_readdata    = rd_q;
            end
            default: begin
            end
        endcase
    end

    assign m_clken = 1'b1;

endmodule : onchip_mem_width_adapter

// File: tb/tb_onchip_mem_width_adapter.sv
// ---------------------------------------------------------------------------
// tb_onchip_mem_width_adapter
//   Self-checking bench: a behavioural 16-bit RAM sits on the master side,
//   and a 32-bit word-level reference memory predicts read data, strobe
//   sequence and latency of every access. Directed cases first, then a
//   randomized run.
// ---------------------------------------------------------------------------
module tb_onchip_mem_width_adapter;

    localparam int MEM_DEPTH = 15360;
    localparam int S_ADDR_W  = 13;
    localparam int M_ADDR_W  = 14;
    localparam int N_WORDS   = MEM_DEPTH / 2;
    localparam int MAX_LAT   = 20;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [S_ADDR_W-1:0] s_address;
    logic [3:0]          s_byteenable;
    logic                s_read;
    logic                s_write;
    logic [31:0]         s_writedata;
    logic [31:0]         s_readdata;
    logic                s_waitrequest;
    logic [M_ADDR_W-1:0] m_address;
    logic [1:0]          m_byteenable;
    logic                m_chipselect;
    logic                m_write;
    logic [15:0]         m_writedata;
    logic                m_clken;
    logic [15:0]         m_readdata;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    always #5 clk = ~clk;

    onchip_mem_width_adapter #(
        .MEM_DEPTH (MEM_DEPTH),
        .S_ADDR_W  (S_ADDR_W),
        .M_ADDR_W  (M_ADDR_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_address     (s_address),
        .s_byteenable  (s_byteenable),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .m_address     (m_address),
        .m_byteenable  (m_byteenable),
        .m_chipselect  (m_chipselect),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_clken       (m_clken),
        .m_readdata    (m_readdata)
    );

    // -----------------------------------------------------------------------
    // 16-bit RAM: registered address, unregistered output, byte writes
    // -----------------------------------------------------------------------
    logic [15:0]         ram [0:MEM_DEPTH-1];
    logic [M_ADDR_W-1:0] ram_addr_q = '0;

    always @(posedge clk) begin
        if (m_chipselect && m_clken && (32'(m_address) < MEM_DEPTH)) begin
            ram_addr_q <= m_address;
            if (m_write) begin
                if (m_byteenable[0]) ram[m_address][7:0]  <= m_writedata[7:0];
                if (m_byteenable[1]) ram[m_address][15:8] <= m_writedata[15:8];
            end
        end
    end

    assign m_readdata = ram[ram_addr_q];

    // 32-bit word reference memory
    logic [31:0] ref_mem [0:N_WORDS-1];

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One complete access through the slave port, checked against the
    // reference memory. Starts and ends with the adapter idle.
    task automatic run_access(input logic [S_ADDR_W-1:0] addr, input logic [3:0] be,
                              input logic rd_en, input logic wr_en, input logic [31:0] wd);
        int            lat = 0;
        int            cs_cnt = 0;
        int            wr_cnt = 0;
        bit            done = 0;
        logic [31:0]   rdata = '0;
        logic [31:0]   exp_rd = '0;
        logic [M_ADDR_W-1:0] aq[$];
        logic [1:0]    bq[$];
        logic [15:0]   dq[$];
        bit            in_range;
        bit            lo_on, hi_on, is_wr;
        int            exp_lat;
        int            idx;

        s_address    = addr;
        s_byteenable = be;
        s_writedata  = wd;
        s_read       = rd_en;
        s_write      = wr_en;

        while (!done && lat < MAX_LAT) begin
            @(posedge clk);
            #1;
            lat++;
            if (m_chipselect) begin
                cs_cnt++;
                aq.push_back(m_address);
                bq.push_back(m_byteenable);
                dq.push_back(m_writedata);
            end
            if (m_write) wr_cnt++;
            if (!s_waitrequest) begin
                done  = 1;
                rdata = s_readdata;
            end else begin
                // The adapter must work only from its latched copy.
                s_address    = S_ADDR_W'($urandom);
                s_byteenable = 4'($urandom);
                s_writedata  = $urandom;
            end
        end
        s_read  = 1'b0;
        s_write = 1'b0;

        if (!done) begin
            check("timeout", 32'(lat), 32'(MAX_LAT + 1));
            pulse_reset();
            return;
        end

        is_wr    = wr_en;
        in_range = (int'(addr) < N_WORDS);
        lo_on    = in_range && (be[1:0] != 2'b00);
        hi_on    = in_range && (be[3:2] != 2'b00);
        exp_lat  = (!lo_on && !hi_on) ? 1 : ((lo_on && hi_on) ? 4 : 3);

        check("latency", 32'(lat), 32'(exp_lat));
        check("cs_cycles", 32'(cs_cnt), 32'(int'(lo_on) + int'(hi_on)));
        check("wr_cycles", 32'(wr_cnt), is_wr ? 32'(int'(lo_on) + int'(hi_on)) : 32'd0);

        idx = 0;
        for (int h = 0; h < 2; h++) begin
            bit on = (h == 0) ? lo_on : hi_on;
            if (on && idx < aq.size()) begin
                check("m_address", 32'(aq[idx]), 32'({addr, 1'(h)}));
                check("m_byteenable", 32'(bq[idx]), 32'(be[2*h +: 2]));
                if (is_wr) check("m_writedata", 32'(dq[idx]), 32'(wd[16*h +: 16]));
                idx++;
            end
        end

        if (is_wr) begin
            if (in_range) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
            end
        end else begin
            if (lo_on) exp_rd[15:0]  = ref_mem[addr][15:0];
            if (hi_on) exp_rd[31:16] = ref_mem[addr][31:16];
            check("s_readdata", rdata, exp_rd);
        end

        n_txn++;
        $display("txn %0d %s addr=%h be=%h wd=%h rd=%h lat=%0d cs=%0d",
                 n_txn, is_wr ? "WR" : "RD", addr, be, wd, rdata, lat, cs_cnt);

        // DONE -> IDLE edge
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        logic [S_ADDR_W-1:0] a;
        logic [3:0]          be;
        logic                r, w;

        for (int i = 0; i < MEM_DEPTH; i++) ram[i] = 16'h0000;
        for (int i = 0; i < N_WORDS; i++) ref_mem[i] = 32'h0;

        reset_n      = 1'b0;
        s_address    = '0;
        s_byteenable = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_writedata  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_waitrequest", 32'(s_waitrequest), 32'd1);
        check("rst_readdata", s_readdata, 32'h0);
        check("rst_chipselect", 32'(m_chipselect), 32'd0);
        check("rst_write", 32'(m_write), 32'd0);
        check("rst_address", 32'(m_address), 32'd0);
        check("rst_byteenable", 32'(m_byteenable), 32'd0);
        check("rst_writedata", 32'(m_writedata), 32'd0);
        check("clken", 32'(m_clken), 32'd1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_access(13'h010, 4'hF, 1'b0, 1'b1, 32'h1234ABCD);
        run_access(13'h010, 4'hF, 1'b1, 1'b0, 32'h0);
        run_access(13'h011, 4'hC, 1'b0, 1'b1, 32'h55550000);
        run_access(13'h011, 4'hC, 1'b1, 1'b0, 32'h0);
        run_access(13'h011, 4'h3, 1'b0, 1'b1, 32'h9999BEEF);
        run_access(13'h011, 4'hF, 1'b1, 1'b0, 32'h0);
        run_access(13'h1E00, 4'hF, 1'b1, 1'b0, 32'h0);
        run_access(13'h1E00, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF);
        run_access(13'h1FFF, 4'hF, 1'b1, 1'b0, 32'h0);
        run_access(13'h1DFF, 4'hF, 1'b0, 1'b1, 32'hA5A55A5A);
        run_access(13'h1DFF, 4'hF, 1'b1, 1'b0, 32'h0);
        run_access(13'h012, 4'h0, 1'b0, 1'b1, 32'h11112222);
        run_access(13'h012, 4'h0, 1'b1, 1'b0, 32'h0);
        run_access(13'h013, 4'hF, 1'b1, 1'b1, 32'h0BADF00D);
        run_access(13'h013, 4'hF, 1'b1, 1'b0, 32'h0);

        // Reset during the HI cycle of a write
        s_address    = 13'h020;
        s_byteenable = 4'hF;
        s_writedata  = 32'hCAFEF00D;
        s_write      = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("hi_cs_before_reset", 32'(m_chipselect), 32'd1);
        check("hi_address_before_reset", 32'(m_address), 32'h041);
        reset_n = 1'b0;
        #1;
        check("async_chipselect", 32'(m_chipselect), 32'd0);
        check("async_write", 32'(m_write), 32'd0);
        check("async_waitrequest", 32'(s_waitrequest), 32'd1);
        s_write = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // The low half completed before reset.
        ref_mem[13'h020][15:0] = 16'hF00D;
        run_access(13'h010, 4'hF, 1'b1, 1'b0, 32'h0);
        run_access(13'h020, 4'hF, 1'b1, 1'b0, 32'h0);

        // Randomized run
        for (int t = 0; t < 120; t++) begin
            if ($urandom_range(0, 9) == 0) a = S_ADDR_W'($urandom_range(7670, 8191));
            else                           a = S_ADDR_W'($urandom_range(0, 31));
            be = 4'($urandom);
            w  = 1'($urandom);
            r  = !w || ($urandom_range(0, 9) == 0);
            run_access(a, be, r, w, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_onchip_mem_width_adapter

// File: doc/onchip_mem_width_adapter.md
Name: onchip_mem_width_adapter

Overview:
- Avalon-MM width adapter placed directly upstream of the 16-bit single-port on-chip RAM.
- Accepts 32-bit word accesses from the Nios II data master and turns each one into one or two sequential 16-bit half-word accesses.
- On reads, reassembles the two 16-bit results into one 32-bit word and ends the transfer by dropping waitrequest.
- Assumes the RAM has a fixed read latency of one clock: the address is registered inside the RAM and the output is unregistered.

Parameters:
- MEM_DEPTH, 15360, number of 16-bit words implemented in the downstream RAM.
- S_ADDR_W, 13, width of the 32-bit word address on the slave side.
- M_ADDR_W, 14, width of the 16-bit word address on the master side; equals S_ADDR_W+1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- s_address  in  S_ADDR_W  32-bit word address.
- s_byteenable  in  4  byte lanes.
- s_read  in  1  read request.
- s_write  in  1  write request.
- s_writedata  in  32  write data.
- s_readdata  out  32  read data; valid when s_waitrequest=0 on a read.
- s_waitrequest  out  1  high while the access is in progress.
- m_address  out  M_ADDR_W  16-bit word address; {latched addr, half}.
- m_byteenable  out  2  byte lanes of the current half.
- m_chipselect  out  1  RAM select.
- m_write  out  1  RAM write strobe.
- m_writedata  out  16  RAM write data.
- m_clken  out  1  tied high.
- m_readdata  in  16  RAM output; valid one clock after the address is presented.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, s_waitrequest=1, s_readdata=0, m_chipselect=0, m_write=0, m_address=0, m_byteenable=0, m_writedata=0.
- All m_* outputs and s_waitrequest are decoded from registered state and latched request registers only. There is no combinational path from any s_* input to any output.
- IDLE, on s_read|s_write:
  - Latch address, byteenable, writedata and direction (write wins if s_read and s_write are both high).
  - Next state: LO if be[1:0]!=0; else HI if be[3:2]!=0; else DONE.
  - Go straight to DONE (no RAM strobe, readdata=0) when be=0, or when {addr,1'b0} >= MEM_DEPTH, i.e. word addresses 7680..8191 at default parameters.
- LO:
  - Drive m_chipselect=1, m_address={addr,0}, m_byteenable=be[1:0], m_write=wr, m_writedata=wd[15:0].
  - Next state: HI if be[3:2]!=0, else WAIT.
- HI:
  - Drive m_chipselect=1, m_address={addr,1}, m_byteenable=be[3:2], m_writedata=wd[31:16].
  - On a read where LO was issued, capture m_readdata into rd[15:0].
  - Next state: WAIT.
- WAIT:
  - No strobes.
  - On a read, capture m_readdata into the half issued in the previous cycle.
  - Next state: DONE.
- DONE:
  - s_waitrequest=0; s_readdata=rd, with any skipped half reading as 0.
  - Clear rd. Next state: IDLE.
- Latency (sample cycle to the DONE cycle, inclusive of DONE):
  - 4 cycles for a two-half access.
  - 3 cycles for a single-half access.
  - 1 cycle for be=0 or an out-of-range address.
  - Reads and writes have identical latency.
- The master holds its request until the DONE cycle (Avalon rule). The adapter uses only its latched copies after IDLE, so input changes mid-access have no effect.
- Back-to-back: a request still asserted in the cycle after DONE is sampled in IDLE; the minimum gap between transfers is 1 cycle.
- Reset during LO/HI: strobes drop immediately. A half-written word may remain in RAM; this is accepted behaviour.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE/LO/HI/WAIT/DONE (3-bit);
  - HALF_LO=0 and HALF_HI=1;
  - MEM_DEPTH default.
- No sub-module; a single FSM plus datapath registers is sufficient.

Test Plan:
- Full write: addr=0x010, be=4'hF, wd=0x1234ABCD.
  - Required: m_address=0x020 with wd 0xABCD, then 0x021 with wd 0x1234.
  - Required: m_write on exactly 2 cycles; s_waitrequest low 4 cycles after the sample cycle.
- Full read back of addr=0x010.
  - Required: s_readdata=0x1234ABCD in the DONE cycle; 2 chipselect cycles, no m_write.
- Partial accesses:
  - Write be=4'b1100, wd=0x5555_0000 to addr 0x011: only m_address=0x023 is strobed, with m_byteenable=2'b11; latency 3.
  - Read of the same address with be=4'b1100: s_readdata=0x5555_0000.
- Out-of-range access to addr=0x1E00 (7680):
  - Required: no m_chipselect; s_waitrequest low in the next cycle; read returns 0.
- be=0 access:
  - Required: no strobes; completes in 1 cycle.
- Reset mid-access: assert reset_n=0 during HI of a write.
  - Required: m_chipselect=0 and s_waitrequest=1 asynchronously.
  - Required: after release, a new read completes normally.
